ctrl_sequencer: RTL

Fetch/decode/execute micro-sequencer for the 3-bit-opcode accumulator CPU. It drives IR/PC/ACC load strobes and memory read/write requests, and owns the Z/C flag write enable. It generates the one-cycle ctrl_jmp_o strobe that the branch decision logic qualifies with the opcode and flags. It also counts retired instructions and halts the core on HLT or on a memory handshake timeout.

---
 rtl/sim_ac_pkg.sv | 30 +++
 rtl/ctrl_mem_wdog.sv | 31 +++
 rtl/ctrl_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/sim_ac_pkg.sv
// Shared encodings for the accumulator CPU: opcodes, sequencer states, ALU ops.
// The branch decision logic and the ALU decode against the same values.
package sim_ac_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_LD  = 3'b010,
      OP_ST  = 3'b011,
      OP_JMP = 3'b100,
      OP_JZ  = 3'b101,
      OP_JC  = 3'b110,
      OP_HLT = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_HALT   = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      ALU_PASS = 2'b00,
      ALU_ADD  = 2'b01,
      ALU_SUB  = 2'b10
   } alu_e;

endpackage

// File: rtl/ctrl_mem_wdog.sv
// Memory handshake watchdog: counts cycles a request waits for ready and
// flags expiry on the cycle the count has reached the limit with ready still low.
module ctrl_mem_wdog #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic req,
   input  logic ready,
   input  logic clear,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

   logic [W-1:0] cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         cnt <= '0;
      else if (clear || !req || ready)
         cnt <= '0;
      else if (cnt != LIMIT)
         cnt <= cnt + W'(1);
   end

   // A ready on the terminal cycle is a normal completion, not an expiry.
   assign expired = req && !ready && (cnt == LIMIT);

endmodule

// File: rtl/ctrl_sequencer.sv
// Fetch/decode/execute micro-sequencer for the 3-bit-opcode accumulator CPU.
// Strobes are decoded from the registered state, the opcode and mem_ready_i.
module ctrl_sequencer
   import sim_ac_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 15,
   parameter int CNT_W          = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             run_i,
   input  logic [2:0]       ir_op_i,
   input  logic             mem_ready_i,
   output logic             mem_rd_o,
   output logic             mem_wr_o,
   output logic             addr_sel_o,
   output logic             ir_load_o,
   output logic             pc_inc_o,
   output logic             ctrl_jmp_o,
   output logic             acc_load_o,
   output logic [1:0]       alu_op_o,
   output logic             flag_we_o,
   output logic             halt_o,
   output logic             err_o,
   output logic [CNT_W-1:0] instr_cnt_o,
   output logic [2:0]       state_o
);

   state_e           state, state_nxt;
   op_e              op;
   logic             expired, err, retire, req;
   logic [CNT_W-1:0] instr_cnt;

   assign op  = op_e'(ir_op_i);
   assign req = mem_rd_o | mem_wr_o;

   ctrl_mem_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .req     (req),
      .ready   (mem_ready_i),
      .clear   (req & mem_ready_i),
      .expired (expired)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (run_i) state_nxt = ST_FETCH;
         ST_FETCH: begin
            if (mem_ready_i)  state_nxt = ST_DECODE;
            else if (expired) state_nxt = ST_HALT;
         end
         ST_DECODE: state_nxt = ST_EXEC;
         ST_EXEC: begin
            case (op)
               OP_JMP, OP_JZ, OP_JC: state_nxt = ST_FETCH;
               OP_HLT:               state_nxt = ST_HALT;
               default: begin
                  if (mem_ready_i)  state_nxt = ST_FETCH;
                  else if (expired) state_nxt = ST_HALT;
               end
            endcase
         end
         ST_HALT:   if (run_i) state_nxt = ST_FETCH;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_rd_o   = 1'b0;
      mem_wr_o   = 1'b0;
      addr_sel_o = 1'b0;
      ir_load_o  = 1'b0;
      pc_inc_o   = 1'b0;
      ctrl_jmp_o = 1'b0;
      acc_load_o = 1'b0;
      alu_op_o   = ALU_PASS;
      flag_we_o  = 1'b0;
      case (state)
         ST_FETCH: begin
            mem_rd_o  = 1'b1;
            ir_load_o = mem_ready_i;
            pc_inc_o  = mem_ready_i;
         end
         ST_EXEC: begin
            case (op)
               OP_ADD, OP_SUB, OP_LD: begin
                  mem_rd_o   = 1'b1;
                  addr_sel_o = 1'b1;
                  alu_op_o   = (op == OP_ADD) ? ALU_ADD :
                               (op == OP_SUB) ? ALU_SUB : ALU_PASS;
                  acc_load_o = mem_ready_i;
                  flag_we_o  = mem_ready_i && (op != OP_LD);
               end
               OP_ST: begin
                  mem_wr_o   = 1'b1;
                  addr_sel_o = 1'b1;
               end
               OP_JMP, OP_JZ, OP_JC: ctrl_jmp_o = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   // A timeout exit from EXEC does not retire the instruction.
   assign retire = (state == ST_EXEC) && (state_nxt != ST_EXEC) && !expired;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err       <= 1'b0;
         instr_cnt <= '0;
      end else begin
         if (expired)                          err <= 1'b1;
         else if (state == ST_HALT && run_i)   err <= 1'b0;
         if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end

   assign halt_o      = (state == ST_HALT);
   assign err_o       = err;
   assign instr_cnt_o = instr_cnt;
   assign state_o     = state;

endmodule
